// File: rtl/button_conditioner.sv
// button_conditioner: synchronise and debounce panel buttons and fast-set switch into mode, fast-set and press pulses.
// Optional long-press auto fast-set enabled by defining LONG_PRESS_FAST_EN.
module button_conditioner #(
  parameter int SYS_CLK_HZ    = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_set_hours_n,
  input  logic       i_set_minutes_n,
  input  logic       i_fast_set_raw,
  output logic [1:0] o_mode,
  output logic       o_fast_set,
  output logic [1:0] o_press
);
  localparam int N = SYS_CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int CW = $clog2(N);
  // bit order {fast_set, hours_n, minutes_n}; released/inactive levels
  localparam logic [2:0] IDLE = 3'b011;
  logic [2:0] raw, meta, s, stable;
  logic [CW-1:0] cnt [3];
  logic hours, minutes, hours_d, minutes_d, long_press;
  logic [1:0] mode_next, press_next;
  assign raw = {i_fast_set_raw, i_set_hours_n, i_set_minutes_n};
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      meta   <= IDLE;
      s      <= IDLE;
      stable <= IDLE;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      meta <= raw;
      s    <= meta;
      for (int i = 0; i < 3; i++) begin
        if (s[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(N - 1)) begin
          stable[i] <= s[i];
          cnt[i]    <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end
  assign hours   = ~stable[1];
  assign minutes = ~stable[0];
  always_comb begin
    mode_next  = (hours && !minutes) ? 2'b10 : (minutes && !hours) ? 2'b01 : 2'b00;
    press_next = {hours & ~hours_d & ~minutes, minutes & ~minutes_d & ~hours};
  end
`ifdef LONG_PRESS_FAST_EN
  localparam int L = SYS_CLK_HZ / 1000 * LONG_PRESS_MS;
  localparam int HW = $clog2(L) + 1;
  logic [HW-1:0] hold;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || o_mode == 2'b00) hold <= '0;
    else if (hold != HW'(L)) hold <= hold + HW'(1);
  end
  // look ahead one cycle so the flag drops together with o_mode returning to run
  assign long_press = (o_mode != 2'b00) && (mode_next != 2'b00) && (hold >= HW'(L - 1));
`else
  assign long_press = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      hours_d    <= 1'b0;
      minutes_d  <= 1'b0;
      o_mode     <= 2'b00;
      o_press    <= 2'b00;
      o_fast_set <= 1'b0;
    end else begin
      hours_d    <= hours;
      minutes_d  <= minutes;
      o_mode     <= mode_next;
      o_press    <= press_next;
      o_fast_set <= stable[2] | long_press;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of reset, debounce, mode encoding, press pulses and fast-set.
module tb_button_conditioner;
  logic clk = 1'b0, rst_n = 1'b0, hours_n = 1'b1, minutes_n = 1'b1, fast_raw = 1'b0;
  logic [1:0] mode, press;
  logic fast;
  int total = 0, passed = 0;
`ifdef LONG_PRESS_FAST_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  always #5 clk = ~clk;

  button_conditioner #(.SYS_CLK_HZ(10_000), .DEBOUNCE_MS(1), .LONG_PRESS_MS(5)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_set_hours_n(hours_n), .i_set_minutes_n(minutes_n),
    .i_fast_set_raw(fast_raw), .o_mode(mode), .o_fast_set(fast), .o_press(press)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; hours_n = 1'b0; minutes_n = 1'b0; fast_raw = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      total++;
      if ({mode, fast, press} !== 5'b0) $display("FAIL reset k=%0d got %b want 00000", k, {mode, fast, press});
      else passed++;
    end
    rst_n = 1'b1; hours_n = 1'b1; minutes_n = 1'b1; fast_raw = 1'b0;
    tick(1);
    total++;
    if ({mode, fast, press} !== 5'b0) $display("FAIL reset_release got %b want 00000", {mode, fast, press});
    else passed++;
    tick(15);
  endtask

  task automatic test_clean_press;
    minutes_n = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      total++;
      if ({mode, press} !== {(k >= 13) ? 2'b01 : 2'b00, (k == 13) ? 2'b01 : 2'b00})
        $display("FAIL press k=%0d got mode=%b press=%b", k, mode, press);
      else passed++;
    end
    minutes_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      total++;
      if ({mode, press} !== {(k >= 13) ? 2'b00 : 2'b01, 2'b00})
        $display("FAIL release k=%0d got mode=%b press=%b", k, mode, press);
      else passed++;
    end
  endtask

  task automatic test_bounce;
    repeat (5) begin
      hours_n = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        tick(1);
        total++;
        if ({mode, press} !== 4'b0) $display("FAIL bounce_low k=%0d got mode=%b press=%b", k, mode, press);
        else passed++;
      end
      hours_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
        tick(1);
        total++;
        if ({mode, press} !== 4'b0) $display("FAIL bounce_high k=%0d got mode=%b press=%b", k, mode, press);
        else passed++;
      end
    end
    hours_n = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      total++;
      if ({mode, press} !== {(k >= 13) ? 2'b10 : 2'b00, (k == 13) ? 2'b10 : 2'b00})
        $display("FAIL bounce_hold k=%0d got mode=%b press=%b", k, mode, press);
      else passed++;
    end
    hours_n = 1'b1;
    tick(14);
    total++;
    if (mode !== 2'b00) $display("FAIL bounce_release got mode=%b want 00", mode);
    else passed++;
  endtask

  task automatic test_conflict;
    minutes_n = 1'b0;
    tick(13);
    total++;
    if ({mode, press} !== 4'b0101) $display("FAIL conflict_min got mode=%b press=%b want 01/01", mode, press);
    else passed++;
    hours_n = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      total++;
      if ({mode, press} !== {(k >= 13) ? 2'b00 : 2'b01, 2'b00})
        $display("FAIL conflict_both k=%0d got mode=%b press=%b", k, mode, press);
      else passed++;
    end
    minutes_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      total++;
      if ({mode, press} !== {(k >= 13) ? 2'b10 : 2'b00, 2'b00})
        $display("FAIL conflict_hours k=%0d got mode=%b press=%b", k, mode, press);
      else passed++;
    end
    hours_n = 1'b1;
    tick(14);
    total++;
    if (mode !== 2'b00) $display("FAIL conflict_release got mode=%b want 00", mode);
    else passed++;
  endtask

  task automatic test_fast_set;
    fast_raw = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      total++;
      if (fast !== (k >= 13)) $display("FAIL fast_rise k=%0d got %b want %b", k, fast, k >= 13);
      else passed++;
    end
    fast_raw = 1'b0;
    tick(5);
    fast_raw = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      total++;
      if (fast !== 1'b1) $display("FAIL fast_glitch k=%0d got %b want 1", k, fast);
      else passed++;
    end
    fast_raw = 1'b0;
    tick(13);
    total++;
    if (fast !== 1'b0) $display("FAIL fast_fall got %b want 0", fast);
    else passed++;
  endtask

  task automatic test_long_press;
    hours_n = 1'b0;
    tick(13);
    total++;
    if (mode !== 2'b10) $display("FAIL long_mode got %b want 10", mode);
    else passed++;
    for (int k = 1; k <= 55; k++) begin
      tick(1);
      total++;
      if (fast !== (LP && k >= 50)) $display("FAIL long_hold k=%0d got %b want %b", k, fast, LP && k >= 50);
      else passed++;
    end
    hours_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      total++;
      if ({mode, fast} !== {(k >= 13) ? 2'b00 : 2'b10, LP && k < 13})
        $display("FAIL long_release k=%0d got mode=%b fast=%b", k, mode, fast);
      else passed++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_conflict();
    test_fast_set();
    test_long_press();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
